// File: rtl/stream_serializer.sv
// +--------------------------------------------------------------------------+
// | stream_serializer: valid/ready word loader, LSB-first serial shifter;     |
// | optional even parity via STREAM_SERIALIZER_PARITY_EN. Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module stream_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             hold,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic             busy
);

`ifdef STREAM_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [FRAME-1:0]   shreg, shreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               bit_valid_n;
  logic               done_n;
  logic               consume;
  logic               last_bit;
  logic               accept;
  logic [FRAME-1:0]   load_frame;

`ifdef STREAM_SERIALIZER_PARITY_EN
  assign load_frame = {^load_data, load_data};
`else
  assign load_frame = load_data;
`endif

  assign consume    = bit_valid && !hold;
  assign last_bit   = (cnt == LAST_CNT);
  assign load_ready = (state == IDLE) || (last_bit && consume);
  assign accept     = load_valid && load_ready;

  // The current bit always sits at shreg[0]; zeros shift in from the top.
  assign bit_out = shreg[0];
  assign busy    = (state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      bit_valid <= bit_valid_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    bit_valid_n = bit_valid;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n     = SHIFT;
          shreg_n     = load_frame;
          cnt_n       = '0;
          bit_valid_n = 1'b1;
        end
      end
      SHIFT: begin
        if (consume) begin
          done_n = last_bit;
          if (accept) begin
            // Back-to-back reload keeps the stream gap-free.
            shreg_n     = load_frame;
            cnt_n       = '0;
            bit_valid_n = 1'b1;
          end else if (last_bit) begin
            state_n     = IDLE;
            shreg_n     = shreg >> 1;
            cnt_n       = '0;
            bit_valid_n = 1'b0;
          end else begin
            shreg_n = shreg >> 1;
            cnt_n   = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_serializer.sv
// +--------------------------------------------------------------------------+
// | tb_stream_serializer: directed self-checking bench. Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_stream_serializer;

  localparam int WIDTH = 16;
`ifdef STREAM_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             hold;
  logic             bit_out;
  logic             bit_valid;
  logic             done;
  logic             busy;

  int total  = 0;
  int passed = 0;

  stream_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .hold       (hold),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic fbit(input logic [WIDTH-1:0] w, input int k);
    return (k < WIDTH) ? w[k] : ^w;
  endfunction

  // Entered in the cycle presenting bit 0; leaves one cycle after done.
  task automatic run_frame(input logic [WIDTH-1:0] w, input int hold_at,
                           input int hold_len, input logic first_done);
    for (int k = 0; k < FRAME; k++) begin
      if (k == hold_at) begin
        hold = 1'b1;
        #1;
        for (int h = 0; h < hold_len; h++) begin
          chk("hold_bit", bit_out, fbit(w, k));
          chk("hold_valid", bit_valid, 1);
          chk("hold_ready", load_ready, 0);
          chk("hold_done", done, (k == 0 && h == 0) ? first_done : 1'b0);
          step();
        end
        hold = 1'b0;
        #1;
      end
      chk("bit", bit_out, fbit(w, k));
      chk("valid", bit_valid, 1);
      chk("busy", busy, 1);
      chk("done_mid", done, (k == 0 && hold_at != 0) ? first_done : 1'b0);
      chk("ready", load_ready, (k == FRAME - 1));
      step();
    end
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", bit_valid, 0);
    chk("bit_end", bit_out, 0);
    step();
    chk("done_once", done, 0);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    hold       = 1'b0;
    #2 rst = 1'b0;
    #10;
    chk("rst_bit", bit_out, 0);
    chk("rst_valid", bit_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", load_ready, 1);
    step();
    rst = 1'b1;
    step();
    chk("idle_ready", load_ready, 1);

    // Single word, no stall.
    load_valid = 1'b1;
    load_data  = 16'b0101_0111_0111_0010;
    #1;
    chk("s1_ready", load_ready, 1);
    step();
    load_valid = 1'b0;
    run_frame(16'b0101_0111_0111_0010, -1, 0, 1'b0);

    // Back-to-back words: FFFF then 0000.
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    step();
    load_data  = 16'h0000;
    #1;
    for (int k = 0; k < FRAME; k++) begin
      chk("b2b_bit", bit_out, fbit(16'hFFFF, k));
      chk("b2b_valid", bit_valid, 1);
      chk("b2b_ready", load_ready, (k == FRAME - 1));
      chk("b2b_done", done, 0);
      step();
    end
    load_valid = 1'b0;
    #1;
    run_frame(16'h0000, -1, 0, 1'b1);

    // Stall for 3 cycles on bit 5; load taken in IDLE despite hold.
    hold       = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hA5C3;
    #1;
    chk("idle_hold_ready", load_ready, 1);
    step();
    load_valid = 1'b0;
    hold       = 1'b0;
    load_data  = 16'h1111;
    #1;
    run_frame(16'hA5C3, 5, 3, 1'b0);

    // Asynchronous reset at bit 9.
    load_valid = 1'b1;
    load_data  = 16'h0200;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("pre_rst_bit9", bit_out, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_bit", bit_out, 0);
    chk("arst_valid", bit_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", load_ready, 1);
    step();
    chk("arst_no_done", done, 0);
    rst = 1'b1;
    step();
    chk("post_rst_done", done, 0);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    step();
    load_valid = 1'b0;
    run_frame(16'h1234, -1, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_serializer.md
# stream_serializer

Upstream stage of the sequence-detector FSM. Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first, one bit per consumed cycle, on a serial line wired to the detector's `inp`. A downstream stall input freezes the current bit. Words can be loaded back-to-back so the detector sees a gap-free stream.

## Interface

Parameters:
- `WIDTH`, 16: bits per word; legal range is 2 or more.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `load_valid`  in  1  `load_data` is offered.
- `load_data`  in  WIDTH  word to serialize; bit 0 goes out first.
- `load_ready`  out  1  the block accepts a word this cycle.
- `hold`  in  1  downstream stall; the current bit is not consumed.
- `bit_out`  out  1  serial data; drives the detector's `inp`.
- `bit_valid`  out  1  `bit_out` carries a frame bit.
- `done`  out  1  one-cycle pulse when the last frame bit is consumed.
- `busy`  out  1  a frame is in progress.

## Operation

- States:
  - IDLE: no frame in progress.
  - SHIFT: presenting frame bits.
- A load is accepted on `load_valid && load_ready`.
- A bit is consumed on `bit_valid && !hold`. The top level gates the detector's clock enable with this same term.
- `load_ready = (state == IDLE) || (last_bit && bit_valid && !hold)`.
  - `last_bit` is asserted when the bit counter equals FRAME-1.
  - FRAME = WIDTH, or WIDTH+1 when parity is enabled (see Configuration).
- IDLE to SHIFT on an accepted load:
  - the shift register takes `load_data`;
  - the bit counter is cleared to 0.
- In SHIFT, on each consumed bit:
  - the counter increments by 1;
  - the shift register shifts right and `bit_out` takes the next bit.
- On consuming the last bit:
  - with an accepted load the block stays in SHIFT, reloads, and clears the counter;
  - without a load it returns to IDLE.
- Counter width is `$clog2(FRAME+1)`. The counter never exceeds FRAME-1, so no wrap occurs.
- `hold` has no effect in IDLE. A load is accepted in IDLE regardless of `hold`.
- While `hold` is high in SHIFT, `bit_out`, `bit_valid` and the counter are frozen, and `load_ready` is 0.
- `load_data` changes while `load_ready` is 0 are ignored.
- `busy` equals (state == SHIFT).

## Timing

- Reset value of every output:
  - `bit_out`, `bit_valid`, `done` and `busy` are 0.
  - `load_ready` is 1, since the block is in IDLE.
  - The shift register and counter are 0.
- Assertion of `rst` is asynchronous. It aborts any frame immediately and discards the word; no `done` is produced.
- Release of `rst` is synchronous to `clk`.
- `bit_out`, `bit_valid`, `done` and `busy` are registered. `load_ready` is combinational from state, counter and `hold`.
- Load accepted at edge N: bit 0 is valid after edge N, in cycle N+1.
- With no stall, bit k appears in cycle N+1+k and the last bit in cycle N+FRAME.
- `done` is high during the cycle that follows consumption of the last bit, for exactly 1 cycle.
- Back-to-back loads: bit 0 of the next word is in the cycle directly after the last bit of the previous word, with zero idle cycles.
  - `bit_valid` stays 1 across the word boundary.
  - `done` pulses in that same cycle.
- Each stall cycle delays all later bits and `done` by 1 cycle.

## Configuration

- Macro: `STREAM_SERIALIZER_PARITY_EN`.
- Defined:
  - One even-parity bit is appended after bit WIDTH-1, so FRAME = WIDTH+1.
  - The parity bit is the XOR of the loaded word, captured at load time.
  - `done` follows the parity bit.
- Undefined:
  - FRAME = WIDTH and no parity logic is present.
  - `done` follows bit WIDTH-1.

## Test plan

1. Reset, then load `16'b0101_0111_0111_0010` with `hold`=0.
   - `bit_out` must be 0,1,0,0, 1,1,1,0, 1,1,1,0, 1,0,1,0 in cycles N+1 to N+16.
   - `done` is high in cycle N+17 and `busy` is 0 afterwards.
2. Repeat scenario 1 with parity enabled.
   - A 17th bit, value 1, appears in cycle N+17.
   - `done` is high in cycle N+18.
3. Load `16'hFFFF`, then hold `load_valid`=1 with `16'h0000` next.
   - 16 ones are followed immediately by 16 zeros.
   - `bit_valid` never drops, `done` pulses once at the boundary, and `load_ready` is 1 only in the last-bit cycle.
4. Assert `hold` for 3 cycles while bit 5 is presented.
   - Bit 5 stays for 4 cycles.
   - All later bits and `done` shift by 3 cycles, and `load_ready` stays 0 during the stall.
5. Assert `rst`=0 asynchronously mid-frame, at bit 9.
   - All outputs are 0 and `load_ready`=1 within the same cycle.
   - No `done` pulse occurs; a new load afterwards starts cleanly from bit 0.
